issue_nway: RTL and testbench

ISSUE_NWAY -- requirements
Module: issue_nway

---
 rtl/issue_nway.sv | 236 +++++++++++++++++++++++
 tb/tb_issue_nway.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_nway.sv
// Multi-slot in-order issue stage with register renaming. It keeps a producer table, assigns ROB tags and emits registered operands.
// Macro ISSUE_CDB_SNOOP_EN is optional. When it is defined, a CDB broadcast in the same cycle supplies source values directly.
module issue_nway #(
    parameter int ISSUE_W = 2,
    parameter int XLEN    = 32,
    parameter int TAG_W   = 5,
    localparam int CW     = $clog2(ISSUE_W + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ISSUE_W-1:0]            dec_valid,
    input  logic [ISSUE_W-1:0][1:0]       dec_fu,
    input  logic [ISSUE_W-1:0][4:0]       dec_rd,
    input  logic [ISSUE_W-1:0][4:0]       dec_rs1,
    input  logic [ISSUE_W-1:0][4:0]       dec_rs2,
    input  logic [ISSUE_W-1:0][XLEN-1:0]  dec_imm,
    input  logic [ISSUE_W-1:0][XLEN-1:0]  dec_pc,
    input  logic [ISSUE_W-1:0][XLEN-1:0]  dec_rs1_val,
    input  logic [ISSUE_W-1:0][XLEN-1:0]  dec_rs2_val,
    input  logic [CW-1:0]                 rs_free,
    input  logic [CW-1:0]                 load_free,
    input  logic [CW-1:0]                 branch_free,
    input  logic [CW-1:0]                 rob_free,
    input  logic                          cdb_valid,
    input  logic [TAG_W-1:0]              cdb_tag,
    input  logic [XLEN-1:0]               cdb_value,
    input  logic                          flush,
    input  logic [TAG_W-1:0]              flush_tag,
    output logic [CW-1:0]                 dec_accept,
    output logic [ISSUE_W-1:0]            out_valid,
    output logic [ISSUE_W-1:0][1:0]       out_fu,
    output logic [ISSUE_W-1:0][TAG_W-1:0] out_tag,
    output logic [ISSUE_W-1:0][4:0]       out_rd,
    output logic [ISSUE_W-1:0][XLEN-1:0]  out_op1,
    output logic [ISSUE_W-1:0][XLEN-1:0]  out_op2,
    output logic [ISSUE_W-1:0]            out_rdy1,
    output logic [ISSUE_W-1:0]            out_rdy2,
    output logic [ISSUE_W-1:0][TAG_W-1:0] out_q1,
    output logic [ISSUE_W-1:0][TAG_W-1:0] out_q2
);
    localparam logic [1:0] FU_NONE   = 2'd0;
    localparam logic [1:0] FU_RS     = 2'd1;
    localparam logic [1:0] FU_LOAD   = 2'd2;
    localparam logic [1:0] FU_BRANCH = 2'd3;

    logic [31:0]            busy_q, busy_d;
    logic [31:0][TAG_W-1:0] ptag_q, ptag_d;
    logic [TAG_W-1:0]       tail_q, tail_d;

    logic [ISSUE_W-1:0]            rdy1_c, rdy2_c, stall_c;
    logic [ISSUE_W-1:0][TAG_W-1:0] q1_c, q2_c, slot_tag_c;
    logic [ISSUE_W-1:0][XLEN-1:0]  op1_c, op2_c;
    int                            acc_n;
    logic [ISSUE_W-1:0]            out_valid_d;

    logic [ISSUE_W-1:0]            out_valid_q, out_rdy1_q, out_rdy2_q;
    logic [ISSUE_W-1:0][1:0]       out_fu_q;
    logic [ISSUE_W-1:0][TAG_W-1:0] out_tag_q, out_q1_q, out_q2_q;
    logic [ISSUE_W-1:0][4:0]       out_rd_q;
    logic [ISSUE_W-1:0][XLEN-1:0]  out_op1_q, out_op2_q;

`ifndef ISSUE_CDB_SNOOP_EN
    logic cdb_value_unused;
    assign cdb_value_unused = ^cdb_value;
`endif

    // Resolve both sources of every slot. Slots that precede a slot in the group are accepted whenever that slot is.
    always_comb begin
        logic [4:0]       r;
        logic [XLEN-1:0]  rv;
        logic             s_rdy, s_hit, s_fwd, use_rs2;
        logic [TAG_W-1:0] s_q, f_tag;
        logic [XLEN-1:0]  s_val;
        r = '0; rv = '0; s_rdy = 1'b0; s_hit = 1'b0; s_fwd = 1'b0; use_rs2 = 1'b0;
        s_q = '0; f_tag = '0; s_val = '0;
        rdy1_c = '0; rdy2_c = '0; stall_c = '0;
        q1_c = '0; q2_c = '0; op1_c = '0; op2_c = '0; slot_tag_c = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            slot_tag_c[k] = tail_q + TAG_W'(k);
            use_rs2 = (dec_fu[k] == FU_RS || dec_fu[k] == FU_BRANCH) && dec_rs2[k] != 5'd0;
            for (int s = 0; s < 2; s++) begin
                r  = (s == 0) ? dec_rs1[k] : dec_rs2[k];
                rv = (s == 0) ? dec_rs1_val[k] : dec_rs2_val[k];
                s_fwd = 1'b0;
                f_tag = '0;
                for (int j = 0; j < ISSUE_W; j++) begin
                    if (j < k && dec_rd[j] == r) begin
                        s_fwd = 1'b1;
                        f_tag = tail_q + TAG_W'(j);
                    end
                end
                s_rdy = 1'b1;
                s_hit = 1'b0;
                s_q   = '0;
                s_val = '0;
                if (r != 5'd0) begin
                    if (s_fwd) begin
                        s_rdy = 1'b0;
                        s_q   = f_tag;
                    end else if (busy_q[r] && cdb_valid && cdb_tag == ptag_q[r]) begin
`ifdef ISSUE_CDB_SNOOP_EN
                        s_val = cdb_value;
`else
                        s_rdy = 1'b0;
                        s_q   = ptag_q[r];
                        s_hit = 1'b1;
`endif
                    end else if (busy_q[r]) begin
                        s_rdy = 1'b0;
                        s_q   = ptag_q[r];
                    end else begin
                        s_val = rv;
                    end
                end
                if (s == 0) begin
                    if ((dec_fu[k] == FU_NONE || dec_fu[k] == FU_BRANCH) && r == 5'd0) begin
                        op1_c[k]  = dec_pc[k];
                        rdy1_c[k] = 1'b1;
                    end else begin
                        op1_c[k]   = s_val;
                        rdy1_c[k]  = s_rdy;
                        q1_c[k]    = s_q;
                        stall_c[k] = stall_c[k] | s_hit;
                    end
                end else if (use_rs2) begin
                    op2_c[k]   = s_val;
                    rdy2_c[k]  = s_rdy;
                    q2_c[k]    = s_q;
                    stall_c[k] = stall_c[k] | s_hit;
                end else begin
                    op2_c[k]  = dec_imm[k];
                    rdy2_c[k] = 1'b1;
                end
            end
        end
    end

    // The accepted group is the longest in-order prefix that fits every free count.
    always_comb begin
        int   n_rs, n_ld, n_br, cnt;
        logic open;
        n_rs = 0; n_ld = 0; n_br = 0; cnt = 0;
        open = !rst && !flush;
        for (int k = 0; k < ISSUE_W; k++) begin
            if (open) begin
                if (dec_valid[k] && !stall_c[k]
                    && n_rs + ((dec_fu[k] == FU_NONE || dec_fu[k] == FU_RS) ? 1 : 0) <= int'(rs_free)
                    && n_ld + ((dec_fu[k] == FU_LOAD) ? 1 : 0) <= int'(load_free)
                    && n_br + ((dec_fu[k] == FU_BRANCH) ? 1 : 0) <= int'(branch_free)
                    && cnt + 1 <= int'(rob_free)) begin
                    n_rs = n_rs + ((dec_fu[k] == FU_NONE || dec_fu[k] == FU_RS) ? 1 : 0);
                    n_ld = n_ld + ((dec_fu[k] == FU_LOAD) ? 1 : 0);
                    n_br = n_br + ((dec_fu[k] == FU_BRANCH) ? 1 : 0);
                    cnt  = cnt + 1;
                end else begin
                    open = 1'b0;
                end
            end
        end
        acc_n = cnt;
    end

    assign dec_accept = CW'(acc_n);

    // Producer table update. Flush takes priority over everything else. A new allocation takes priority over a CDB clear.
    always_comb begin
        busy_d      = busy_q;
        ptag_d      = ptag_q;
        tail_d      = tail_q;
        out_valid_d = '0;
        if (flush) begin
            busy_d = '0;
            tail_d = flush_tag;
        end else begin
            if (cdb_valid) begin
                for (int r = 1; r < 32; r++) begin
                    if (busy_q[r] && ptag_q[r] == cdb_tag) busy_d[r] = 1'b0;
                end
            end
            for (int k = 0; k < ISSUE_W; k++) begin
                if (k < acc_n) begin
                    out_valid_d[k] = 1'b1;
                    if (dec_rd[k] != 5'd0) begin
                        busy_d[dec_rd[k]] = 1'b1;
                        ptag_d[dec_rd[k]] = slot_tag_c[k];
                    end
                end
            end
            tail_d = tail_q + TAG_W'(acc_n);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            ptag_q      <= '0;
            tail_q      <= '0;
            out_valid_q <= '0;
            out_fu_q    <= '0;
            out_tag_q   <= '0;
            out_rd_q    <= '0;
            out_op1_q   <= '0;
            out_op2_q   <= '0;
            out_rdy1_q  <= '0;
            out_rdy2_q  <= '0;
            out_q1_q    <= '0;
            out_q2_q    <= '0;
        end else begin
            busy_q      <= busy_d;
            ptag_q      <= ptag_d;
            tail_q      <= tail_d;
            out_valid_q <= out_valid_d;
            out_fu_q    <= dec_fu;
            out_tag_q   <= slot_tag_c;
            out_rd_q    <= dec_rd;
            out_op1_q   <= op1_c;
            out_op2_q   <= op2_c;
            out_rdy1_q  <= rdy1_c;
            out_rdy2_q  <= rdy2_c;
            out_q1_q    <= q1_c;
            out_q2_q    <= q2_c;
        end
    end

    assign out_valid = out_valid_q;
    assign out_fu    = out_fu_q;
    assign out_tag   = out_tag_q;
    assign out_rd    = out_rd_q;
    assign out_op1   = out_op1_q;
    assign out_op2   = out_op2_q;
    assign out_rdy1  = out_rdy1_q;
    assign out_rdy2  = out_rdy2_q;
    assign out_q1    = out_q1_q;
    assign out_q2    = out_q2_q;

endmodule

// File: tb/tb_issue_nway.sv
// Bench for issue_nway. It runs directed scenarios and then randomized cycles.
// Every cycle is checked against a producer-table reference model kept in the bench.
module tb_issue_nway;
  localparam int NW = 2;
  localparam int XL = 32;
  localparam int TW = 5;
  localparam int CW = 2;
  localparam logic [1:0] FU_NONE = 2'd0, FU_RS = 2'd1, FU_LOAD = 2'd2, FU_BR = 2'd3;

  logic clk = 1'b0;
  logic rst;
  logic [NW-1:0] dec_valid;
  logic [NW-1:0][1:0] dec_fu;
  logic [NW-1:0][4:0] dec_rd, dec_rs1, dec_rs2;
  logic [NW-1:0][XL-1:0] dec_imm, dec_pc, dec_rs1_val, dec_rs2_val;
  logic [CW-1:0] rs_free, load_free, branch_free, rob_free;
  logic cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [XL-1:0] cdb_value;
  logic flush;
  logic [TW-1:0] flush_tag;
  logic [CW-1:0] dec_accept;
  logic [NW-1:0] out_valid, out_rdy1, out_rdy2;
  logic [NW-1:0][1:0] out_fu;
  logic [NW-1:0][TW-1:0] out_tag, out_q1, out_q2;
  logic [NW-1:0][4:0] out_rd;
  logic [NW-1:0][XL-1:0] out_op1, out_op2;

  issue_nway #(.ISSUE_W(NW), .XLEN(XL), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_fu(dec_fu), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_imm(dec_imm), .dec_pc(dec_pc), .dec_rs1_val(dec_rs1_val), .dec_rs2_val(dec_rs2_val),
    .rs_free(rs_free), .load_free(load_free), .branch_free(branch_free), .rob_free(rob_free),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .flush(flush), .flush_tag(flush_tag),
    .dec_accept(dec_accept),
    .out_valid(out_valid), .out_fu(out_fu), .out_tag(out_tag), .out_rd(out_rd),
    .out_op1(out_op1), .out_op2(out_op2), .out_rdy1(out_rdy1), .out_rdy2(out_rdy2),
    .out_q1(out_q1), .out_q2(out_q2)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass = 0;
  logic [TW-1:0] exp_q[$];

  // reference model state
  bit m_busy[32];
  logic [TW-1:0] m_tag[32];
  logic [TW-1:0] m_tail;
  int e_acc;
  bit e_valid[NW], e_rdy1[NW], e_rdy2[NW];
  logic [1:0] e_fu[NW];
  logic [4:0] e_rd[NW];
  logic [TW-1:0] e_tag[NW], e_q1[NW], e_q2[NW];
  logic [XL-1:0] e_op1[NW], e_op2[NW];

  task automatic resolve(input int k, input logic [4:0] r, input logic [XL-1:0] v,
                         output bit rdy, output logic [TW-1:0] q, output logic [XL-1:0] val, output bit hit);
    int prod;
    prod = -1;
    rdy = 1; q = '0; val = '0; hit = 0;
    if (r == 5'd0) return;
    for (int j = 0; j < k; j++) if (dec_rd[j] == r) prod = j;
    if (prod >= 0) begin
      rdy = 0; q = m_tail + 5'(prod);
    end else if (m_busy[r] && cdb_valid && cdb_tag == m_tag[r]) begin
`ifdef ISSUE_CDB_SNOOP_EN
      val = cdb_value;
`else
      rdy = 0; q = m_tag[r]; hit = 1;
`endif
    end else if (m_busy[r]) begin
      rdy = 0; q = m_tag[r];
    end else begin
      val = v;
    end
  endtask

  task automatic model_cycle();
    int n_rs, n_ld, n_br;
    bit open, r1, r2, h1, h2, use2;
    logic [TW-1:0] q1, q2;
    logic [XL-1:0] v1, v2;
    e_acc = 0;
    for (int k = 0; k < NW; k++) e_valid[k] = 0;
    if (rst) begin
      for (int r = 0; r < 32; r++) begin m_busy[r] = 0; m_tag[r] = '0; end
      m_tail = '0;
      return;
    end
    if (flush) begin
      for (int r = 0; r < 32; r++) m_busy[r] = 0;
      m_tail = flush_tag;
      return;
    end
    n_rs = 0; n_ld = 0; n_br = 0; open = 1;
    for (int k = 0; k < NW; k++) begin
      if (open && dec_valid[k]) begin
        n_rs += (dec_fu[k] == FU_NONE || dec_fu[k] == FU_RS) ? 1 : 0;
        n_ld += (dec_fu[k] == FU_LOAD) ? 1 : 0;
        n_br += (dec_fu[k] == FU_BR) ? 1 : 0;
        use2 = (dec_fu[k] == FU_RS || dec_fu[k] == FU_BR) && dec_rs2[k] != 5'd0;
        resolve(k, dec_rs1[k], dec_rs1_val[k], r1, q1, v1, h1);
        resolve(k, dec_rs2[k], dec_rs2_val[k], r2, q2, v2, h2);
        if (n_rs > rs_free || n_ld > load_free || n_br > branch_free || k + 1 > rob_free
            || h1 || (use2 && h2)) begin
          open = 0;
        end else begin
          e_valid[k] = 1; e_acc = k + 1;
          e_fu[k] = dec_fu[k]; e_rd[k] = dec_rd[k]; e_tag[k] = m_tail + 5'(k);
          if ((dec_fu[k] == FU_NONE || dec_fu[k] == FU_BR) && dec_rs1[k] == 5'd0) begin
            e_op1[k] = dec_pc[k]; e_rdy1[k] = 1; e_q1[k] = '0;
          end else begin
            e_op1[k] = v1; e_rdy1[k] = r1; e_q1[k] = q1;
          end
          if (use2) begin
            e_op2[k] = v2; e_rdy2[k] = r2; e_q2[k] = q2;
          end else begin
            e_op2[k] = dec_imm[k]; e_rdy2[k] = 1; e_q2[k] = '0;
          end
        end
      end else begin
        open = 0;
      end
    end
    // CDB frees first; this cycle's allocations then overwrite
    if (cdb_valid)
      for (int r = 0; r < 32; r++) if (m_busy[r] && m_tag[r] == cdb_tag) m_busy[r] = 0;
    for (int k = 0; k < e_acc; k++)
      if (dec_rd[k] != 5'd0) begin m_busy[dec_rd[k]] = 1; m_tag[dec_rd[k]] = m_tail + 5'(k); end
    m_tail = m_tail + 5'(e_acc);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    model_cycle();
    tick();
  endtask

  task automatic idle_inputs();
    rst = 0; flush = 0; flush_tag = '0;
    dec_valid = '0; dec_fu = '0; dec_rd = '0; dec_rs1 = '0; dec_rs2 = '0;
    dec_imm = '0; dec_pc = '0; dec_rs1_val = '0; dec_rs2_val = '0;
    rs_free = 2'd2; load_free = 2'd2; branch_free = 2'd2; rob_free = 2'd2;
    cdb_valid = 0; cdb_tag = '0; cdb_value = '0;
  endtask

  task automatic set_slot(input int k, input logic [1:0] fu, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [XL-1:0] imm, input logic [XL-1:0] v1);
    dec_valid[k] = 1; dec_fu[k] = fu; dec_rd[k] = rd; dec_rs1[k] = rs1; dec_rs2[k] = rs2;
    dec_imm[k] = imm; dec_pc[k] = 32'h1000 + 32'(4 * k); dec_rs1_val[k] = v1; dec_rs2_val[k] = 32'hBEEF;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; flush = 1; flush_tag = 5'd7; cdb_valid = 1;
    set_slot(0, FU_RS, 5'd5, 5'd1, 5'd2, 32'd3, 32'd9);
    set_slot(1, FU_LOAD, 5'd6, 5'd1, 5'd0, 32'd4, 32'd9);
    #2;
    n_checks++; if (dec_accept !== 2'd0) $display("FAIL reset_accept: got %0d want 0", dec_accept); else n_pass++;
    cycle();
    cycle();
    n_checks++; if (out_valid !== '0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_tag !== '0 || out_rd !== '0 || out_fu !== '0) $display("FAIL reset_fields: tag %h rd %h fu %h want 0", out_tag, out_rd, out_fu); else n_pass++;
    n_checks++; if (out_op1 !== '0 || out_op2 !== '0 || out_rdy1 !== '0 || out_rdy2 !== '0 || out_q1 !== '0 || out_q2 !== '0)
      $display("FAIL reset_operands: op1 %h op2 %h want 0", out_op1, out_op2); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_dependency();
    idle_inputs();
    set_slot(0, FU_RS, 5'd5, 5'd0, 5'd0, 32'd7, 32'd0);
    set_slot(1, FU_RS, 5'd6, 5'd5, 5'd5, 32'd0, 32'd11);
    #2;
    n_checks++; if (dec_accept !== 2'd2) $display("FAIL dep_accept: got %0d want 2", dec_accept); else n_pass++;
    cycle();
    n_checks++; if (out_valid !== 2'b11) $display("FAIL dep_valid: got %b want 11", out_valid); else n_pass++;
    n_checks++; if (out_tag[0] !== 5'd0 || out_tag[1] !== 5'd1) $display("FAIL dep_tags: got %0d,%0d want 0,1", out_tag[0], out_tag[1]); else n_pass++;
    n_checks++; if (out_op1[0] !== 32'd0 || out_op2[0] !== 32'd7 || out_rdy1[0] !== 1'b1 || out_rdy2[0] !== 1'b1)
      $display("FAIL dep_slot0_ops: op1 %h op2 %h want 0,7", out_op1[0], out_op2[0]); else n_pass++;
    n_checks++; if (out_rdy1[1] !== 1'b0 || out_rdy2[1] !== 1'b0) $display("FAIL dep_slot1_rdy: got %b%b want 00", out_rdy1[1], out_rdy2[1]); else n_pass++;
    n_checks++; if (out_q1[1] !== 5'd0 || out_q2[1] !== 5'd0) $display("FAIL dep_slot1_q: got %0d,%0d want 0,0", out_q1[1], out_q2[1]); else n_pass++;
    idle_inputs();
    cycle();
    n_checks++; if (out_valid !== 2'b00) $display("FAIL dep_idle_valid: got %b want 00", out_valid); else n_pass++;
  endtask

  task automatic test_cdb();
    idle_inputs();
    flush = 1; flush_tag = 5'd3;
    cycle();
    idle_inputs();
    set_slot(0, FU_RS, 5'd5, 5'd0, 5'd0, 32'd1, 32'd0);
    cycle();
    idle_inputs();
    set_slot(0, FU_RS, 5'd6, 5'd5, 5'd0, 32'h10, 32'hAAAA);
    cdb_valid = 1; cdb_tag = 5'd3; cdb_value = 32'h55;
    #2;
`ifdef ISSUE_CDB_SNOOP_EN
    n_checks++; if (dec_accept !== 2'd1) $display("FAIL cdb_accept: got %0d want 1", dec_accept); else n_pass++;
    cycle();
    n_checks++; if (out_valid[0] !== 1'b1 || out_op1[0] !== 32'h55 || out_rdy1[0] !== 1'b1)
      $display("FAIL cdb_snoop_op1: valid %b op1 %h rdy %b want 1,55,1", out_valid[0], out_op1[0], out_rdy1[0]); else n_pass++;
`else
    n_checks++; if (dec_accept !== 2'd0) $display("FAIL cdb_stall: got %0d want 0", dec_accept); else n_pass++;
    cycle();
    cdb_valid = 0;
    #2;
    n_checks++; if (dec_accept !== 2'd1) $display("FAIL cdb_retry_accept: got %0d want 1", dec_accept); else n_pass++;
    cycle();
    n_checks++; if (out_valid[0] !== 1'b1 || out_op1[0] !== 32'hAAAA || out_rdy1[0] !== 1'b1)
      $display("FAIL cdb_retry_op1: valid %b op1 %h rdy %b want 1,aaaa,1", out_valid[0], out_op1[0], out_rdy1[0]); else n_pass++;
`endif
    n_checks++; if (out_tag[0] !== 5'd4) $display("FAIL cdb_tag: got %0d want 4", out_tag[0]); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_load_limit();
    idle_inputs();
    load_free = 2'd1;
    set_slot(0, FU_LOAD, 5'd7, 5'd0, 5'd0, 32'd8, 32'd0);
    set_slot(1, FU_LOAD, 5'd8, 5'd0, 5'd0, 32'd12, 32'd0);
    #2;
    n_checks++; if (dec_accept !== 2'd1) $display("FAIL load_accept1: got %0d want 1", dec_accept); else n_pass++;
    cycle();
    n_checks++; if (out_valid !== 2'b01 || out_rd[0] !== 5'd7) $display("FAIL load_out1: valid %b rd %0d want 01,7", out_valid, out_rd[0]); else n_pass++;
    set_slot(0, FU_LOAD, 5'd8, 5'd0, 5'd0, 32'd12, 32'd0);
    set_slot(1, FU_LOAD, 5'd9, 5'd0, 5'd0, 32'd16, 32'd0);
    load_free = 2'd2;
    #2;
    n_checks++; if (dec_accept !== 2'd2) $display("FAIL load_accept2: got %0d want 2", dec_accept); else n_pass++;
    cycle();
    n_checks++; if (out_valid !== 2'b11 || out_rd[0] !== 5'd8 || out_rd[1] !== 5'd9)
      $display("FAIL load_out2: valid %b rd %0d,%0d want 11,8,9", out_valid, out_rd[0], out_rd[1]); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_tag_wrap();
    idle_inputs();
    flush = 1; flush_tag = 5'd31;
    cycle();
    idle_inputs();
    set_slot(0, FU_RS, 5'd1, 5'd0, 5'd0, 32'd1, 32'd0);
    set_slot(1, FU_RS, 5'd2, 5'd0, 5'd0, 32'd2, 32'd0);
    #2;
    n_checks++; if (dec_accept !== 2'd2) $display("FAIL wrap_accept: got %0d want 2", dec_accept); else n_pass++;
    cycle();
    n_checks++; if (out_tag[0] !== 5'd31 || out_tag[1] !== 5'd0) $display("FAIL wrap_tags: got %0d,%0d want 31,0", out_tag[0], out_tag[1]); else n_pass++;
    idle_inputs();
    set_slot(0, FU_RS, 5'd3, 5'd0, 5'd0, 32'd3, 32'd0);
    cycle();
    n_checks++; if (out_tag[0] !== 5'd1) $display("FAIL wrap_next_tag: got %0d want 1", out_tag[0]); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_flush();
    idle_inputs();
    set_slot(0, FU_RS, 5'd5, 5'd0, 5'd0, 32'd1, 32'd0);
    cycle();
    idle_inputs();
    set_slot(0, FU_RS, 5'd10, 5'd0, 5'd0, 32'd1, 32'd0);
    set_slot(1, FU_RS, 5'd11, 5'd0, 5'd0, 32'd1, 32'd0);
    cdb_valid = 1; cdb_tag = m_tag[5] + 5'd1; cdb_value = 32'h77;
    flush = 1; flush_tag = 5'd9;
    #2;
    n_checks++; if (dec_accept !== 2'd0) $display("FAIL flush_accept: got %0d want 0", dec_accept); else n_pass++;
    cycle();
    n_checks++; if (out_valid !== 2'b00) $display("FAIL flush_valid: got %b want 00", out_valid); else n_pass++;
    idle_inputs();
    set_slot(0, FU_RS, 5'd6, 5'd5, 5'd0, 32'd0, 32'h1234);
    cycle();
    n_checks++; if (out_tag[0] !== 5'd9) $display("FAIL flush_next_tag: got %0d want 9", out_tag[0]); else n_pass++;
    n_checks++; if (out_rdy1[0] !== 1'b1 || out_op1[0] !== 32'h1234) $display("FAIL flush_table_clear: rdy %b op1 %h want 1,1234", out_rdy1[0], out_op1[0]); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_random();
    int r;
    idle_inputs();
    for (int c = 0; c < 400; c++) begin
      flush = ($urandom_range(0, 24) == 0);
      flush_tag = 5'($urandom);
      rs_free = 2'($urandom_range(0, 2)); load_free = 2'($urandom_range(0, 2));
      branch_free = 2'($urandom_range(0, 2)); rob_free = 2'($urandom_range(0, 2));
      for (int k = 0; k < NW; k++) begin
        dec_valid[k] = ($urandom_range(0, 4) != 0);
        dec_fu[k] = 2'($urandom_range(0, 3));
        dec_rd[k] = 5'($urandom_range(0, 7)); dec_rs1[k] = 5'($urandom_range(0, 7)); dec_rs2[k] = 5'($urandom_range(0, 7));
        dec_imm[k] = $urandom; dec_pc[k] = $urandom; dec_rs1_val[k] = $urandom; dec_rs2_val[k] = $urandom;
      end
      cdb_valid = $urandom_range(0, 1) == 1;
      r = $urandom_range(1, 7);
      cdb_tag = m_busy[r] ? m_tag[r] : 5'($urandom);
      cdb_value = $urandom;
      #2;
      model_cycle();
      n_checks++; if (dec_accept !== 2'(e_acc)) $display("FAIL rand_accept c%0d: got %0d want %0d", c, dec_accept, e_acc); else n_pass++;
      for (int k = 0; k < e_acc; k++) exp_q.push_back(e_tag[k]);
      tick();
      for (int k = 0; k < NW; k++) begin
        n_checks++; if (out_valid[k] !== e_valid[k]) $display("FAIL rand_valid c%0d s%0d: got %b want %b", c, k, out_valid[k], e_valid[k]); else n_pass++;
        if (e_valid[k]) begin
          logic [TW-1:0] t;
          t = exp_q.pop_front();
          n_checks++; if (out_tag[k] !== t) $display("FAIL rand_tag c%0d s%0d: got %0d want %0d", c, k, out_tag[k], t); else n_pass++;
          n_checks++; if (out_fu[k] !== e_fu[k] || out_rd[k] !== e_rd[k]) $display("FAIL rand_fu_rd c%0d s%0d: got %0d,%0d want %0d,%0d", c, k, out_fu[k], out_rd[k], e_fu[k], e_rd[k]); else n_pass++;
          n_checks++; if (out_rdy1[k] !== e_rdy1[k] || out_rdy2[k] !== e_rdy2[k]) $display("FAIL rand_rdy c%0d s%0d: got %b%b want %b%b", c, k, out_rdy1[k], out_rdy2[k], e_rdy1[k], e_rdy2[k]); else n_pass++;
          if (e_rdy1[k]) begin
            n_checks++; if (out_op1[k] !== e_op1[k]) $display("FAIL rand_op1 c%0d s%0d: got %h want %h", c, k, out_op1[k], e_op1[k]); else n_pass++;
          end else begin
            n_checks++; if (out_q1[k] !== e_q1[k]) $display("FAIL rand_q1 c%0d s%0d: got %0d want %0d", c, k, out_q1[k], e_q1[k]); else n_pass++;
          end
          if (e_rdy2[k]) begin
            n_checks++; if (out_op2[k] !== e_op2[k]) $display("FAIL rand_op2 c%0d s%0d: got %h want %h", c, k, out_op2[k], e_op2[k]); else n_pass++;
          end else begin
            n_checks++; if (out_q2[k] !== e_q2[k]) $display("FAIL rand_q2 c%0d s%0d: got %0d want %0d", c, k, out_q2[k], e_q2[k]); else n_pass++;
          end
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    set_slot(0, FU_RS, 5'd12, 5'd0, 5'd0, 32'd1, 32'd0);
    set_slot(1, FU_BR, 5'd0, 5'd0, 5'd0, 32'd2, 32'd0);
    cycle();
    n_checks++; if (out_valid !== 2'b11) $display("FAIL midrst_pre_valid: got %b want 11", out_valid); else n_pass++;
    rst = 1;
    #2;
    n_checks++; if (dec_accept !== 2'd0) $display("FAIL midrst_accept: got %0d want 0", dec_accept); else n_pass++;
    cycle();
    n_checks++; if (out_valid !== 2'b00) $display("FAIL midrst_valid: got %b want 00", out_valid); else n_pass++;
    idle_inputs();
    set_slot(0, FU_RS, 5'd12, 5'd0, 5'd0, 32'd1, 32'd0);
    cycle();
    n_checks++; if (out_valid[0] !== 1'b1 || out_tag[0] !== 5'd0) $display("FAIL midrst_first_tag: valid %b tag %0d want 1,0", out_valid[0], out_tag[0]); else n_pass++;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    for (int r = 0; r < 32; r++) begin m_busy[r] = 0; m_tag[r] = '0; end
    m_tail = '0;
    test_reset();
    test_dependency();
    test_cdb();
    test_load_limit();
    test_tag_wrap();
    test_flush();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
